// File: rtl/updi_break_seq_if.sv
// updi_break_seq_if: request/status bundle between the UPDI link controller and the BREAK sequencer
// Signals: start, abort, n_breaks, break_len, gap_len (controller -> sequencer);
//          busy, line, done (sequencer -> controller / pin driver).
// Modports: master = link controller, slave = sequencer.
interface updi_break_seq_if #(
    parameter int CNT_W = 16,
    parameter int NB_W  = 3
);
    logic             start;
    logic             abort;
    logic [NB_W-1:0]  n_breaks;
    logic [CNT_W-1:0] break_len;
    logic [CNT_W-1:0] gap_len;
    logic             busy;
    logic             line;
    logic             done;
    modport master (output start, abort, n_breaks, break_len, gap_len, input busy, line, done);
    modport slave  (input start, abort, n_breaks, break_len, gap_len, output busy, line, done);
endinterface

// File: rtl/updi_break_seq.sv
// updi_break_seq: drives the UPDI line through a train of N BREAK (low) pulses separated by high gaps
// Ports: clk      - system clock, rising edge
//        rst      - synchronous active-high reset
//        bif      - slave modport: start/abort/n_breaks/break_len/gap_len in; busy/line/done out
// Optional build macro UPDI_BREAK_GUARD_EN: after the last BREAK hold the line high (busy) for
// eff(gap_len) cycles in a GUARD state before completing, giving an idle interval ahead of SYNC.
module updi_break_seq #(
    parameter int CNT_W = 16,
    parameter int NB_W  = 3
) (
    input logic             clk,
    input logic             rst,
    updi_break_seq_if.slave bif
);
`ifdef UPDI_BREAK_GUARD_EN
    typedef enum logic [2:0] {S_IDLE, S_BRK, S_GAP, S_GUARD, S_FIN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_BRK, S_GAP, S_FIN} state_t;
`endif
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_bl_m1;
    logic [CNT_W-1:0] r_gl_m1;
    logic [NB_W-1:0]  r_rem;
    logic             r_busy;
    logic             r_line;
    logic             r_done;
    logic [CNT_W-1:0] w_bl_m1;
    logic [CNT_W-1:0] w_gl_m1;

    // Lengths are stored as eff(x)-1 so a zero request still yields one cycle.
    assign w_bl_m1 = (bif.break_len == '0) ? '0 : bif.break_len - CNT_W'(1);
    assign w_gl_m1 = (bif.gap_len == '0) ? '0 : bif.gap_len - CNT_W'(1);

    assign bif.busy = r_busy;
    assign bif.line = r_line;
    assign bif.done = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bl_m1 <= '0;
            r_gl_m1 <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_line  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE && bif.abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_line  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // abort wins over a simultaneous start
                        if (bif.start && !bif.abort) begin
                            r_bl_m1 <= w_bl_m1;
                            r_gl_m1 <= w_gl_m1;
                            if (bif.n_breaks != '0) begin
                                r_state <= S_BRK;
                                r_line  <= 1'b0;
                                r_busy  <= 1'b1;
                                r_cnt   <= w_bl_m1;
                                r_rem   <= bif.n_breaks - NB_W'(1);
                            end else begin
                                r_state <= S_FIN;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_BRK: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end else if (r_rem != '0) begin
                            r_state <= S_GAP;
                            r_line  <= 1'b1;
                            r_cnt   <= r_gl_m1;
                        end else begin
`ifdef UPDI_BREAK_GUARD_EN
                            r_state <= S_GUARD;
                            r_line  <= 1'b1;
                            r_cnt   <= r_gl_m1;
`else
                            r_state <= S_FIN;
                            r_line  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                    S_GAP: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end else begin
                            r_state <= S_BRK;
                            r_line  <= 1'b0;
                            r_cnt   <= r_bl_m1;
                            r_rem   <= r_rem - NB_W'(1);
                        end
                    end
`ifdef UPDI_BREAK_GUARD_EN
                    S_GUARD: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end else begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
`endif
                    // FIN holds done for its single cycle; a start seen here is dropped
                    S_FIN: r_state <= S_IDLE;
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_line  <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
